// File: rtl/alu181_nibble_seq.sv
// alu181_nibble_seq: runs one 4-bit 74181 slice over NIBBLES cycles, LSB nibble first,
// rippling the slice carry-out back into its carry-in to build a wide ALU operation.
module alu181_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic [3:0]           req_s,
    input  logic                 req_m,
    input  logic                 req_cnb,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic                 alu_cnb,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cn4b,
    input  logic                 alu_aeb,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [4*NIBBLES-1:0] resp_f,
    output logic                 resp_cn4b,
    output logic                 resp_aeb
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [3:0]      s_reg;
    logic            m_reg;
    logic            carry_reg;
    logic            aeb_acc;
    logic            accept;
    logic            last_nib;
    logic [IW+1:0]   nib_lsb;

    assign accept   = (state == ST_IDLE) && req_valid;
    assign last_nib = (idx == IW'(NIBBLES - 1));
    assign nib_lsb  = {idx, 2'b00};

    // State register; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_nib)   state_nxt = ST_DONE;
            ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake flags and slice drive; slice is idle (carry-in negated) outside RUN
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_a      = 4'h0;
        alu_b      = 4'h0;
        alu_s      = 4'h0;
        alu_m      = 1'b0;
        alu_cnb    = 1'b1;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_RUN: begin
                alu_a   = a_reg[nib_lsb +: 4];
                alu_b   = b_reg[nib_lsb +: 4];
                alu_s   = s_reg;
                alu_m   = m_reg;
                alu_cnb = carry_reg;
            end
            ST_DONE: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch, nibble index, carry chain and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= 4'h0;
            m_reg     <= 1'b0;
            carry_reg <= 1'b1;
            aeb_acc   <= 1'b1;
            resp_f    <= '0;
            resp_cn4b <= 1'b1;
            resp_aeb  <= 1'b0;
        end else if (accept) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            s_reg     <= req_s;
            m_reg     <= req_m;
            carry_reg <= req_cnb;
            idx       <= '0;
            aeb_acc   <= 1'b1;
        end else if (state == ST_RUN) begin
            resp_f[nib_lsb +: 4] <= alu_f;
            carry_reg            <= alu_cn4b;
            aeb_acc              <= aeb_acc & alu_aeb;
            if (last_nib) begin
                resp_cn4b <= alu_cn4b;
                resp_aeb  <= aeb_acc & alu_aeb;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule
